// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin front end that shares one square-root core among NUM_REQ
// requesters. Single outstanding operation; the core is started with a one-cycle core_go
// and its result is returned with the index of the requester that issued it.
//
// Optional feature (compile-time macro SQRT_ARBITER_BYPASS_EN): a one-entry result memo
// {valid, operand, result}. An accepted operand that matches the memo is answered directly
// on the next cycle without starting the core.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req_valid  per-requester operand valid        req_data  packed operands, i at [i*WIDTH +: WIDTH]
//   req_ready  one-hot accept strobe
//   rsp_valid  result valid                       rsp_ready result consumer ready
//   rsp_data   square-root result                 rsp_id    requester index of the result
//   core_go    start strobe to the shared core    core_in   operand to the core
//   core_out   core result                        core_done core completion pulse
//   busy       high whenever not idle
module sqrt_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FRAC_WIDTH = 0,
    parameter int unsigned NUM_REQ    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_data,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic                       core_go,
    output logic [WIDTH-1:0]           core_in,
    input  logic [WIDTH-1:0]           core_out,
    input  logic                       core_done,
    output logic                       busy
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    // FRAC_WIDTH only describes the attached core; it just has to fit in the word.
    if (NUM_REQ < 2 || NUM_REQ > 16 || FRAC_WIDTH >= WIDTH) begin : g_bad_params
        $error("sqrt_arbiter: NUM_REQ must be 2..16 and FRAC_WIDTH < WIDTH");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   last_grant_q, last_grant_d;
    logic [IdW-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0] operand_q, operand_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             wait_first_q, wait_first_d;

    logic             any_req;
    logic [IdW-1:0]   grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             core_cap;
    logic             bypass_hit;
    logic [WIDTH-1:0] byp_result;

    // Round-robin pick, starting one past the last served requester.
    always_comb begin
        int unsigned cand;
        any_req   = 1'b0;
        grant_idx = last_grant_q;
        cand      = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last_grant_q) + k) % NUM_REQ;
            if (!any_req && req_valid[cand[IdW-1:0]]) begin
                any_req   = 1'b1;
                grant_idx = cand[IdW-1:0];
            end
        end
    end

    assign grant_data = req_data[32'(grant_idx) * WIDTH +: WIDTH];

    // The first WAIT cycle may carry a stale done from the core's previous job.
    assign core_cap = (state_q == StWait) && !wait_first_q && core_done;

`ifdef SQRT_ARBITER_BYPASS_EN
    logic             byp_valid_q;
    logic [WIDTH-1:0] byp_op_q, byp_res_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byp_valid_q <= 1'b0;
            byp_op_q    <= '0;
            byp_res_q   <= '0;
        end else if (core_cap) begin
            byp_valid_q <= 1'b1;
            byp_op_q    <= operand_q;
            byp_res_q   <= core_out;
        end
    end

    assign bypass_hit = byp_valid_q && (byp_op_q == grant_data);
    assign byp_result = byp_res_q;
`else
    assign bypass_hit = 1'b0;
    assign byp_result = '0;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        operand_d    = operand_q;
        result_d     = result_q;
        wait_first_d = wait_first_q;
        req_ready    = '0;
        core_go      = 1'b0;
        rsp_valid    = 1'b0;

        case (state_q)
            StIdle: begin
                if (any_req) begin
                    req_ready[grant_idx] = 1'b1;
                    grant_d              = grant_idx;
                    operand_d            = grant_data;
                    if (bypass_hit) begin
                        result_d = byp_result;
                        state_d  = StResp;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                core_go      = 1'b1;
                wait_first_d = 1'b1;
                state_d      = StWait;
            end
            StWait: begin
                if (wait_first_q) begin
                    wait_first_d = 1'b0;
                end else if (core_done) begin
                    result_d = core_out;
                    state_d  = StResp;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= IdW'(NUM_REQ - 1);
            grant_q      <= '0;
            operand_q    <= '0;
            result_q     <= '0;
            wait_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            operand_q    <= operand_d;
            result_q     <= result_d;
            wait_first_q <= wait_first_d;
        end
    end

    assign rsp_data = result_q;
    assign rsp_id   = grant_q;
    assign core_in  = operand_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Self-checking bench for sqrt_arbiter: directed scenarios followed by randomized traffic,
// all judged by a transaction-level reference model (round-robin pick, integer sqrt,
// response timing derived from accept / core completion events).
module tb_sqrt_arbiter;
    localparam int W  = 32;
    localparam int NR = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [NR*W-1:0]   req_data;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_data;
    logic [1:0]        rsp_id;
    logic              core_go;
    logic [W-1:0]      core_in;
    logic [W-1:0]      core_out;
    logic              core_done;
    logic              busy;

    always #5 clk = ~clk;

    sqrt_arbiter #(.WIDTH(W), .FRAC_WIDTH(0), .NUM_REQ(NR)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .core_go(core_go), .core_in(core_in),
        .core_out(core_out), .core_done(core_done), .busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // stimulus intent, applied in the drive slot just after each rising edge
    logic [NR-1:0] want_valid = '0;
    logic [W-1:0]  want_data [NR];
    logic          want_rsp_ready = 1'b1;
    bit            rst_hold = 1'b1;
    bit            rand_mode = 1'b0;
    int            stale_mode = 0;   // 0 never, 1 always, 2 random
    int            lat_min = 1, lat_max = 3;
    bit            spur_en = 1'b0;

    // attached core model
    bit            go_seen = 1'b0;
    int            countdown = 0;
    logic [W-1:0]  core_op;
    bit            true_done = 1'b0;
    int            go_count = 0;

    // reference model
    bit            m_out = 1'b0, m_rsp = 1'b0, m_hit = 1'b0;
    int            m_last = NR - 1, m_id = 0, m_acc_cyc = 0;
    logic [W-1:0]  m_op, m_exp;
    bit            c_valid = 1'b0;
    logic [W-1:0]  c_op;

    int            log_id[$];
    logic [W-1:0]  log_data[$];
    bit            rsp_seen = 1'b0, rsp_done_now = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
        longint r;
        longint xv;
        xv = longint'(x);
        r  = longint'($sqrt(real'(xv)));
        while (r * r > xv) r--;
        while ((r + 1) * (r + 1) <= xv) r++;
        return r[W-1:0];
    endfunction

    function automatic int rr_pick(input int last, input logic [NR-1:0] v);
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (last + k) % NR;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] gen_op();
        logic [W-1:0] pool [5];
        pool[0] = 0; pool[1] = 1; pool[2] = 81; pool[3] = 144; pool[4] = 32'hffff_ffff;
        if ($urandom_range(3) == 0) return pool[$urandom_range(4)];
        return $urandom;
    endfunction

    function automatic int lid(input int k);
        return (k < log_id.size()) ? log_id[k] : -1;
    endfunction

    function automatic logic [W-1:0] ldata(input int k);
        return (k < log_data.size()) ? log_data[k] : 32'hdead_beef;
    endfunction

    task automatic drive();
        if (rand_mode) begin
            for (int i = 0; i < NR; i++) begin
                if (!want_valid[i]) begin
                    if ($urandom_range(3) == 0) begin
                        want_valid[i] = 1'b1;
                        want_data[i]  = gen_op();
                    end
                end else if ($urandom_range(31) == 0) begin
                    want_valid[i] = 1'b0;   // requester gives up before being granted
                end
            end
            want_rsp_ready = ($urandom_range(2) != 0);
        end
        reset     = !rst_hold;
        req_valid = want_valid;
        for (int i = 0; i < NR; i++) req_data[i*W +: W] = want_data[i];
        rsp_ready = want_rsp_ready;
        core_done = 1'b0;
        core_out  = $urandom;
        true_done = 1'b0;
        if (go_seen) begin
            go_seen   = 1'b0;
            core_done = (stale_mode == 1) || (stale_mode == 2 && $urandom_range(1) == 1);
            countdown = $urandom_range(lat_max, lat_min);
        end else if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
                core_done = 1'b1;
                core_out  = isqrt(core_op);
                true_done = 1'b1;
            end
        end else if (spur_en && $urandom_range(7) == 0) begin
            core_done = 1'b1;
        end
    endtask

    task automatic observe();
        int            g;
        logic [NR-1:0] exp_ready;
        bit            exp_go;
        cyc++;
        rsp_done_now = 1'b0;
        if (!reset) begin
            check("rst_req_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_core_go", core_go, 0);
            check("rst_busy", busy, 0);
            check("rst_rsp_data", rsp_data, 0);
            check("rst_rsp_id", rsp_id, 0);
            check("rst_core_in", core_in, 0);
            m_out = 1'b0; m_rsp = 1'b0; m_hit = 1'b0; m_last = NR - 1; c_valid = 1'b0;
            return;
        end
        g = -1;
        exp_ready = '0;
        if (!m_out && |req_valid) begin
            g = rr_pick(m_last, req_valid);
            exp_ready[g] = 1'b1;
        end
        check("req_ready", req_ready, exp_ready);
        check("busy", busy, m_out);
        check("rsp_valid", rsp_valid, m_rsp);
        exp_go = m_out && !m_hit && (cyc == m_acc_cyc + 1);
        check("core_go", core_go, exp_go);
        if (m_out && !m_hit && cyc > m_acc_cyc && !m_rsp) check("core_in", core_in, m_op);
        if (m_rsp) begin
            check("rsp_data", rsp_data, m_exp);
            check("rsp_id", rsp_id, m_id);
            rsp_seen = 1'b1;
        end
        if (core_go) begin
            go_seen = 1'b1;
            core_op = core_in;
            go_count++;
        end
        // response handshake
        if (m_rsp && rsp_ready) begin
            m_out = 1'b0; m_rsp = 1'b0; m_last = m_id;
            log_id.push_back(int'(rsp_id));
            log_data.push_back(rsp_data);
            rsp_done_now = 1'b1;
        end
        // genuine completion of an operation still in flight
        if (core_done && true_done && m_out && !m_rsp && !m_hit) begin
            m_rsp = 1'b1;
            c_valid = 1'b1;
            c_op = m_op;
        end
        if (g >= 0) begin
            m_out = 1'b1; m_id = g; m_op = req_data[g*W +: W]; m_exp = isqrt(m_op);
            m_acc_cyc = cyc;
            m_hit = 1'b0;
`ifdef SQRT_ARBITER_BYPASS_EN
            m_hit = c_valid && (c_op == m_op);
`endif
            if (m_hit) m_rsp = 1'b1;
            want_valid[g] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        observe();
    endtask

    task automatic run_until_resp(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (log_id.size() < target && n < budget) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, log_id.size() >= target, 1);
    endtask

    initial begin
        int base;
        int n;
        for (int i = 0; i < NR; i++) want_data[i] = '0;
        req_valid = '0; req_data = '0; rsp_ready = 1'b0; core_done = 1'b0; core_out = '0;

        rst_hold = 1'b1;
        repeat (3) step();
        rst_hold = 1'b0;

        // single request, 144 -> 12, one core_go
        base = go_count;
        want_data[0] = 144; want_valid[0] = 1'b1;
        run_until_resp(1, 40, "t1");
        check("t1_id", lid(0), 0);
        check("t1_data", ldata(0), 12);
        check("t1_go_pulses", go_count - base, 1);

        // last grant 0: requesters 1 and 3 together, 1 wins first
        want_data[1] = 100; want_data[3] = 49; want_valid[1] = 1'b1; want_valid[3] = 1'b1;
        run_until_resp(3, 80, "t2");
        check("t2_first_id", lid(1), 1);
        check("t2_first_data", ldata(1), 10);
        check("t2_second_id", lid(2), 3);
        check("t2_second_data", ldata(2), 7);

        // consumer stalls five cycles in RESP; competing request must not be accepted
        want_rsp_ready = 1'b0;
        want_data[2] = 625; want_valid[2] = 1'b1;
        rsp_seen = 1'b0;
        n = 0;
        while (!rsp_seen && n < 30) begin step(); n++; end
        check("t3_rsp_timeout", rsp_seen, 1);
        want_data[0] = 16; want_valid[0] = 1'b1;
        repeat (4) step();
        check("t3_held_rsp_valid", rsp_valid, 1);
        want_rsp_ready = 1'b1;
        step();
        check("t3_done_6th", rsp_done_now, 1);
        check("t3_id", lid(3), 2);
        check("t3_data", ldata(3), 25);
        run_until_resp(5, 40, "t3b");
        check("t3b_data", ldata(4), 4);

        // reset during WAIT, core completes afterwards: nothing reported
        lat_min = 10; lat_max = 10;
        base = go_count;
        want_data[1] = 900; want_valid[1] = 1'b1;
        n = 0;
        while (go_count == base && n < 20) begin step(); n++; end
        check("t4_go_timeout", go_count - base, 1);
        repeat (2) step();
        rst_hold = 1'b1;
        repeat (2) step();
        rst_hold = 1'b0;
        repeat (15) step();
        check("t4_busy", busy, 0);
        check("t4_rsp_valid", rsp_valid, 0);
        check("t4_no_resp", log_id.size(), 5);

        // stale done right after core_go must be ignored
        stale_mode = 1; lat_min = 3; lat_max = 3;
        want_data[2] = 1000000; want_valid[2] = 1'b1;
        run_until_resp(6, 40, "t5");
        check("t5_id", lid(5), 2);
        check("t5_data", ldata(5), 1000);
        stale_mode = 0;

`ifdef SQRT_ARBITER_BYPASS_EN
        // same operand twice: second served from the memo without the core
        lat_min = 2; lat_max = 2;
        base = go_count;
        want_data[0] = 81; want_valid[0] = 1'b1;
        run_until_resp(7, 40, "t6a");
        want_data[0] = 81; want_valid[0] = 1'b1;
        run_until_resp(8, 40, "t6b");
        check("t6_first", ldata(6), 9);
        check("t6_second", ldata(7), 9);
        check("t6_go_pulses", go_count - base, 1);
`endif

        // randomized traffic with stale and spurious done pulses
        rand_mode = 1'b1; stale_mode = 2; lat_min = 1; lat_max = 5; spur_en = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0; want_valid = '0; want_rsp_ready = 1'b1; spur_en = 1'b0;
        repeat (40) step();
        check("final_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, operand/result width; FRAC_WIDTH, 0, fractional bits of attached core; NUM_REQ, 4, requester count (2..16).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  NUM_REQ  per-requester operand valid.
REQ-005 req_data  input  NUM_REQ*WIDTH  per-requester operands, requester i at bits [i*WIDTH +: WIDTH].
REQ-006 req_ready  output  NUM_REQ  one-hot accept strobe.
REQ-007 rsp_valid  output  1  result valid.
REQ-008 rsp_ready  input  1  result consumer ready.
REQ-009 rsp_data  output  WIDTH  square-root result.
REQ-010 rsp_id  output  $clog2(NUM_REQ)  index of the requester the result belongs to.
REQ-011 core_go  output  1  start strobe to the shared sqrt core.
REQ-012 core_in  output  WIDTH  operand to the core.
REQ-013 core_out  input  WIDTH  core result.
REQ-014 core_done  input  1  core completion pulse.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-017 IDLE: if any req_valid is high, the block SHALL grant round-robin, searching from (last_grant+1) mod NUM_REQ, pulse req_ready[grant] for one cycle, latch the operand and grant, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-018 A transfer SHALL occur only when req_valid[i] and req_ready[i] are both high; at most one req_ready bit SHALL be high in any cycle.
REQ-019 ISSUE: the block SHALL drive core_go=1 for exactly one cycle with core_in equal to the latched operand, then go to WAIT.
REQ-020 core_in SHALL hold the latched operand from ISSUE through WAIT.
REQ-021 WAIT: core_done SHALL be ignored in the first cycle after core_go, because the core can emit a stale done pulse there; a later core_done SHALL latch core_out and move the FSM to RESP.
REQ-022 core_done in IDLE, ISSUE or RESP SHALL be ignored.
REQ-023 RESP: rsp_valid=1 with rsp_data and rsp_id held stable until rsp_ready; on rsp_valid and rsp_ready the block SHALL update last_grant to the served index and return to IDLE.
REQ-024 No new request SHALL be accepted before the current response completes; the block is single-outstanding.
REQ-025 Latency without bypass SHALL be: accept at cycle N, core_go at N+1, rsp_valid the cycle after the qualified core_done.
REQ-026 A request that deasserts before it is granted SHALL be dropped silently; fairness SHALL guarantee service within NUM_REQ grants.

Reset
REQ-027 While reset is low: state=IDLE, last_grant=NUM_REQ-1, req_ready=0, rsp_valid=0, core_go=0, busy=0, rsp_data=0, rsp_id=0, core_in=0, bypass entry invalid.
REQ-028 Reset asserted in any state SHALL abort the operation with no response issued; a core_done arriving after release SHALL be ignored per REQ-022.

Configuration
REQ-029 Macro SQRT_ARBITER_BYPASS_EN defined: the block SHALL keep one entry {valid, operand, result}, written on every core-completed result; an accepted operand matching a valid entry SHALL go IDLE->RESP on the next cycle with the stored result and no core_go.
REQ-030 Macro SQRT_ARBITER_BYPASS_EN undefined: no bypass storage SHALL exist and every request SHALL pass through ISSUE/WAIT.

Verification
REQ-031 WIDTH=32, FRAC_WIDTH=0: req 0 sends 144, rsp_ready=1 -> rsp_data=12, rsp_id=0, exactly one core_go pulse.
REQ-032 Last grant 0, req_valid[1] and req_valid[3] simultaneous with 100 and 49 -> first response id 1 data 10, then id 3 data 7.
REQ-033 rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id are stable, no req_ready pulses, completion on the 6th cycle.
REQ-034 Reset pulsed low during WAIT, then core_done arrives -> no rsp_valid, state IDLE, busy=0.
REQ-035 Stale core_done the cycle after core_go, true done later -> only the true core_out is reported.
REQ-036 With SQRT_ARBITER_BYPASS_EN, 81 sent twice -> both results are 9, the second has no core_go and rsp_valid one cycle after accept.
